// File: rtl/apb_cfg_master_if.sv
// rtl/apb_cfg_master_if.sv - request/response and APB bus bundle for apb_cfg_master
interface apb_cfg_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, busy,
               PADDR, PWRITE, PSEL, PENABLE, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy,
               PADDR, PWRITE, PSEL, PENABLE, PWDATA
    );
endinterface

// File: rtl/apb_cfg_master.sv
// rtl/apb_cfg_master.sv - single-outstanding APB initiator for the config register slave
// Optional ACCESS timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_cfg_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_cfg_master_if.master    bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, GAP} state_t;

    state_t                state;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic                  psel_q;
    logic                  penable_q;
    logic [DATA_WIDTH-1:0] pwdata_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0]      to_cnt;
    logic                  rsp_error_q;
    assign bus.rsp_error = rsp_error_q;
`else
    // Constant 0 without the timeout feature.
    assign bus.rsp_error = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwdata_q    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            to_cnt      <= '0;
            rsp_error_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        paddr_q     <= bus.req_addr;
                        pwrite_q    <= bus.req_write;
                        pwdata_q    <= bus.req_wdata;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                    to_cnt    <= '0;
`endif
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // PREADY takes priority over a timeout on the same edge.
                    if (bus.PREADY) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
                        rsp_error_q <= 1'b0;
`endif
                        state       <= GAP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (int'(to_cnt) >= TIMEOUT_CYCLES - 1) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_error_q <= 1'b1;
                        state       <= GAP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                GAP: begin
                    rsp_valid_q <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_error_q <= 1'b0;
`endif
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWDATA    = pwdata_q;
endmodule

// File: tb/tb_apb_cfg_master.sv
// tb/tb_apb_cfg_master.sv - directed bench for apb_cfg_master with a wait-state APB slave model
module tb_apb_cfg_master;
    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_cfg_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    apb_cfg_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    // Slave model: PREADY after wait_states ACCESS cycles, never while hang is set.
    logic        hang = 1'b0;
    int          wait_states = 0;
    int          acc_cnt = 0;
    logic [31:0] rd_value = '0;

    assign bus.PREADY = bus.PSEL && bus.PENABLE && !hang && (acc_cnt >= wait_states);
    assign bus.PRDATA = rd_value;

    always @(posedge PCLK) begin
        if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    // Bus monitor sampled on the falling edge.
    int          psel_cyc = 0, pen_cyc = 0, setup_cyc = 0, rsp_cyc = 0;
    int          err_cyc = 0, dbl_rsp = 0, unstable = 0, nogap = 0;
    logic        prev_psel = 1'b0, prev_rsp = 1'b0;
    logic [40:0] prev_fields = '0;
    logic [40:0] xfer_log[$];

    always @(negedge PCLK) begin
        if (bus.PSEL) psel_cyc <= psel_cyc + 1;
        if (bus.PSEL && bus.PENABLE) pen_cyc <= pen_cyc + 1;
        if (bus.PSEL && !bus.PENABLE) begin
            setup_cyc <= setup_cyc + 1;
            xfer_log.push_back({bus.PWRITE, bus.PADDR, bus.PWDATA});
        end
        if (bus.rsp_valid) rsp_cyc <= rsp_cyc + 1;
        if (bus.rsp_error) err_cyc <= err_cyc + 1;
        if (bus.rsp_valid && prev_rsp) dbl_rsp <= dbl_rsp + 1;
        if (bus.PSEL && prev_psel && ({bus.PWRITE, bus.PADDR, bus.PWDATA} != prev_fields))
            unstable <= unstable + 1;
        if (bus.PSEL && !bus.PENABLE && prev_psel) nogap <= nogap + 1;
        prev_psel   <= bus.PSEL;
        prev_rsp    <= bus.rsp_valid;
        prev_fields <= {bus.PWRITE, bus.PADDR, bus.PWDATA};
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
        #1;
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d, input logic keep);
        logic found;
        found = 1'b0;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.req_ready) begin
                tick();
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!keep) bus.req_valid = 1'b0;
        chk("accept", 64'(found), 64'd1);
    endtask

    task automatic wait_rsp(input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.rsp_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("rsp_wait", 64'(found), 64'd1);
    endtask

    int b_psel, b_pen, b_setup, b_rsp, b_err;

    task automatic snap();
        b_psel = psel_cyc; b_pen = pen_cyc; b_setup = setup_cyc;
        b_rsp = rsp_cyc;   b_err = err_cyc;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        tick(); tick();

        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_psel",      64'(bus.PSEL),      64'd0);
        chk("rst_penable",   64'(bus.PENABLE),   64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_paddr",     64'(bus.PADDR),     64'd0);
        chk("rst_rdata",     64'(bus.rsp_rdata), 64'd0);
        chk("rst_error",     64'(bus.rsp_error), 64'd0);
        PRESETn = 1'b1;
        tick();

        // Write, one wait state.
        wait_states = 1; rd_value = 32'hDEAD_BEEF;
        snap();
        issue(1'b1, 8'h04, 32'h0000_0001, 1'b0);
        wait_rsp(20);
        chk("wr_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("wr_error", 64'(bus.rsp_error), 64'd0);
        tick();
        chk("wr_req_ready_after", 64'(bus.req_ready), 64'd1);
        chk("wr_rsp_drop",        64'(bus.rsp_valid), 64'd0);
        tick();
        chk("wr_psel_cycles", 64'(psel_cyc - b_psel), 64'd3);
        chk("wr_pen_cycles",  64'(pen_cyc - b_pen),   64'd2);
        chk("wr_rsp_pulses",  64'(rsp_cyc - b_rsp),   64'd1);
        chk("wr_stable",      64'(unstable),          64'd0);
        chk("wr_fields",      64'(xfer_log[$]),       {23'd0, 1'b1, 8'h04, 32'h0000_0001});

        // Read, zero wait: cycle-exact latency.
        wait_states = 0; rd_value = 32'h8000_0001;
        issue(1'b0, 8'h18, 32'h0, 1'b0);
        chk("rd_e0_psel",    64'(bus.PSEL),      64'd1);
        chk("rd_e0_penable", 64'(bus.PENABLE),   64'd0);
        chk("rd_e0_ready",   64'(bus.req_ready), 64'd0);
        chk("rd_e0_busy",    64'(bus.busy),      64'd1);
        tick();
        chk("rd_e1_penable", 64'(bus.PENABLE),   64'd1);
        chk("rd_e1_rsp",     64'(bus.rsp_valid), 64'd0);
        tick();
        chk("rd_e2_rsp",     64'(bus.rsp_valid), 64'd1);
        chk("rd_e2_rdata",   64'(bus.rsp_rdata), 64'h8000_0001);
        chk("rd_e2_psel",    64'(bus.PSEL),      64'd0);
        chk("rd_e2_ready",   64'(bus.req_ready), 64'd0);
        tick();
        chk("rd_e3_ready",   64'(bus.req_ready), 64'd1);
        chk("rd_e3_rsp",     64'(bus.rsp_valid), 64'd0);
        chk("rd_e3_busy",    64'(bus.busy),      64'd0);

        // Back-to-back writes with req_valid held.
        tick();
        snap();
        issue(1'b1, 8'h0C, 32'h0000_00A0, 1'b1);
        issue(1'b1, 8'h10, 32'h0000_00B0, 1'b1);
        issue(1'b1, 8'h14, 32'h0000_00C0, 1'b0);
        for (int i = 0; i < 100 && (rsp_cyc - b_rsp) < 3; i++) tick();
        for (int i = 0; i < 6; i++) tick();
        chk("b2b_transfers", 64'(setup_cyc - b_setup), 64'd3);
        chk("b2b_rsp",       64'(rsp_cyc - b_rsp),     64'd3);
        chk("b2b_gap",       64'(nogap),               64'd0);
        chk("b2b_x0", 64'(xfer_log[xfer_log.size()-3]), {23'd0, 1'b1, 8'h0C, 32'h0000_00A0});
        chk("b2b_x1", 64'(xfer_log[xfer_log.size()-2]), {23'd0, 1'b1, 8'h10, 32'h0000_00B0});
        chk("b2b_x2", 64'(xfer_log[xfer_log.size()-1]), {23'd0, 1'b1, 8'h14, 32'h0000_00C0});

        // Reset while stalled in ACCESS.
        hang = 1'b1;
        issue(1'b0, 8'h30, 32'h0, 1'b0);
        tick(); tick();
        chk("rst_mid_in_access", 64'({bus.PSEL, bus.PENABLE}), 64'd3);
        snap();
        #2 PRESETn = 1'b0;
        #1;
        chk("rst_mid_psel",    64'(bus.PSEL),    64'd0);
        chk("rst_mid_penable", 64'(bus.PENABLE), 64'd0);
        tick(); tick();
        chk("rst_mid_ready", 64'(bus.req_ready), 64'd1);
        PRESETn = 1'b1;
        hang = 1'b0; wait_states = 0; rd_value = 32'h1234_ABCD;
        tick();
        chk("rst_mid_no_rsp", 64'(rsp_cyc - b_rsp), 64'd0);
        issue(1'b0, 8'h20, 32'h0, 1'b0);
        wait_rsp(20);
        chk("post_rst_rdata", 64'(bus.rsp_rdata), 64'h1234_ABCD);
        chk("post_rst_addr",  64'(xfer_log[$]),   {23'd0, 1'b0, 8'h20, 32'h0});
        tick(); tick();

`ifdef APB_MASTER_TIMEOUT_EN
        hang = 1'b1; rd_value = 32'h0000_5555;
        snap();
        issue(1'b0, 8'h24, 32'h0, 1'b0);
        wait_rsp(30);
        chk("to_error", 64'(bus.rsp_error), 64'd1);
        chk("to_rdata", 64'(bus.rsp_rdata), 64'd0);
        tick(); tick();
        chk("to_access_cycles", 64'(pen_cyc - b_pen), 64'd4);
        hang = 1'b0; wait_states = 3;
        snap();
        issue(1'b0, 8'h24, 32'h0, 1'b0);
        wait_rsp(30);
        chk("to_race_error", 64'(bus.rsp_error), 64'd0);
        chk("to_race_rdata", 64'(bus.rsp_rdata), 64'h5555);
        tick(); tick();
        chk("to_race_cycles", 64'(pen_cyc - b_pen), 64'd4);
`else
        hang = 1'b1;
        snap();
        issue(1'b0, 8'h08, 32'h0, 1'b0);
        for (int i = 0; i < 1000; i++) tick();
        chk("hang_pen_cycles", 64'(pen_cyc - b_pen), 64'd1000);
        chk("hang_no_rsp",     64'(rsp_cyc - b_rsp), 64'd0);
        chk("hang_no_error",   64'(err_cyc - b_err), 64'd0);
        chk("hang_psel",       64'({bus.PSEL, bus.PENABLE}), 64'd3);
        hang = 1'b0; rd_value = 32'h0BAD_F00D;
        wait_rsp(10);
        chk("hang_release_rdata", 64'(bus.rsp_rdata), 64'h0BAD_F00D);
        chk("hang_release_error", 64'(bus.rsp_error), 64'd0);
        tick(); tick();
`endif
        chk("single_cycle_rsp", 64'(dbl_rsp), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_cfg_master.md
Name: apb_cfg_master

Overview:
- APB initiator that turns simple register-access requests into APB SETUP/ACCESS transfers toward the configuration register slave.
- Used by the host-side command path and test harnesses to program the TPU: enables, matrix addresses, strides and start, plus done-polling.
- One transfer in flight at a time; every accepted request yields exactly one response pulse.

Parameters:
- ADDR_WIDTH, 8, width of PADDR / req_addr (matches `REG_ADDRWIDTH)
- DATA_WIDTH, 32, width of PWDATA / PRDATA / req_wdata / rsp_rdata (matches `REG_DATAWIDTH)
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before abort; only used with APB_MASTER_TIMEOUT_EN

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  master idle, request accepted when req_valid&req_ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  register address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_error  out  1  transfer aborted by timeout
- busy  out  1  transfer in progress (state != IDLE)
- PADDR  out  ADDR_WIDTH  APB address
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready

Behaviour:
- All outputs are registered. Reset value 0 for every output except req_ready, which is 1.
- PRESETn low at any time clears state to IDLE immediately, deasserts PSEL/PENABLE and drops any in-flight transfer; no response is issued for it.
- States are IDLE, SETUP, ACCESS and GAP.
- IDLE:
  - req_ready=1.
  - On req_valid at edge E0: latch addr/write/wdata into PADDR/PWRITE/PWDATA, set PSEL=1, PENABLE=0, req_ready=0, go to SETUP.
- SETUP (one cycle): at E1 set PENABLE=1, go to ACCESS.
- ACCESS:
  - PADDR/PWRITE/PWDATA/PSEL/PENABLE are held stable.
  - PREADY is sampled at each edge.
  - On PREADY=1: PSEL=0, PENABLE=0, rsp_valid=1, rsp_error=0, rsp_rdata = PWRITE ? 0 : PRDATA, go to GAP.
- GAP (one cycle): rsp_valid=1 during this cycle only and PSEL stays low. At the next edge rsp_valid=0, req_ready=1, go to IDLE.
- The mandatory GAP guarantees PSEL is low for at least one cycle between transfers, so a registered-PREADY slave returns to idle.
- Latency:
  - Zero-wait slave (PREADY high in the first ACCESS cycle): rsp_valid visible after E2, req_ready after E3.
  - Each wait state adds one cycle.
- rsp_valid has no backpressure; the consumer must accept it in that cycle.
- req_valid while busy is ignored (req_ready=0). Request fields are not sampled outside the IDLE accept edge.
- PADDR/PWDATA keep their last values when PSEL=0; they are don't-care to the slave.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES, the master aborts: PSEL=0, PENABLE=0, rsp_valid=1, rsp_error=1, rsp_rdata=0, go to GAP.
  - PREADY arriving on the same edge as the terminal count wins: normal completion, rsp_error=0.
- When not defined:
  - No counter exists; ACCESS waits for PREADY indefinitely.
  - rsp_error is constant 0.

Test Plan:
- Write with a one-wait-state slave: req addr=0x04, wdata=0x0000_0001, write=1.
  - PSEL high 3 cycles, PENABLE high 2 cycles.
  - PADDR=0x04, PWDATA=0x1 stable throughout.
  - One rsp_valid pulse with rsp_rdata=0, rsp_error=0.
  - req_ready returns 1 cycle after the pulse.
- Read with a zero-wait slave returning PRDATA=0x8000_0001: rsp_valid one cycle after the first ACCESS cycle, rsp_rdata=0x8000_0001.
- Back-to-back: req_valid held high with 3 writes (addr 0x0C, 0x10, 0x14).
  - Exactly 3 transfers in order.
  - PSEL low for at least 1 cycle between them.
  - 3 rsp_valid pulses.
  - No request accepted while busy.
- Reset mid-transfer: assert PRESETn=0 in ACCESS with PREADY=0.
  - PSEL/PENABLE drop asynchronously, no rsp_valid.
  - After release, req_ready=1 and a new read of 0x20 completes normally.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY tied 0:
  - Abort after 4 ACCESS cycles with rsp_valid=1, rsp_error=1, rsp_rdata=0.
  - Repeat with PREADY rising on the 4th cycle: rsp_error=0.
- Without APB_MASTER_TIMEOUT_EN, PREADY held 0 for 1000 cycles: PSEL/PENABLE stay high, no rsp_valid, rsp_error=0 throughout.
